// File: rtl/svm_coef_loader_pkg.sv
// Shared constants and state encoding for the SVM coefficient loader.
// Derived widths are computed here so every file agrees on them.
package svm_coef_loader_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int COEF_W  = 12;
    localparam int N_COEF  = 105;
    localparam int N_WORDS = 36;
    localparam int ADDR_W  = 6;
    localparam int IN_W    = 32;
    localparam int RAM_DW  = COEF_W * N_COEF;
    localparam int BEATS   = ceil_div(RAM_DW, IN_W);
    localparam int BEAT_W  = $clog2(BEATS);
    // Useful bits carried by the final beat of each word.
    localparam int LAST_W  = RAM_DW - (BEATS - 1) * IN_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WR      = 3'd2,
        S_RD      = 3'd3,
        S_CMP     = 3'd4,
        S_BIAS    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/svm_beat_pack.sv
// Packs narrow stream beats little-endian into one RAM-width word.
// Flags the last beat of a word so the sequencer can hand the word off.
module svm_beat_pack
    import svm_coef_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_accept,
    input  logic [IN_W-1:0]   i_data,
    output logic [RAM_DW-1:0] o_asm,
    output logic              o_last
);

    logic [BEAT_W-1:0] r_beat;
    logic [RAM_DW-1:0] r_asm;

    assign o_last = (r_beat == BEAT_W'(BEATS - 1));
    assign o_asm  = r_asm;

    // NOTE: the assembly register is reset because it drives the RAM write bus directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_asm  <= '0;
        end else begin
            if (i_clr)
                r_beat <= '0;
            else if (i_accept)
                r_beat <= o_last ? '0 : r_beat + BEAT_W'(1);

            if (i_accept) begin
                for (int b = 0; b < BEATS - 1; b++) begin
                    if (r_beat == BEAT_W'(b))
                        r_asm[b*IN_W +: IN_W] <= i_data;
                end
                if (o_last)
                    r_asm[RAM_DW-1 -: LAST_W] <= i_data[LAST_W-1:0];
            end
        end
    end

endmodule

// File: rtl/svm_coef_loader.sv
// Loads (or verifies) the SVM coefficient RAM and bias from a narrow stream,
// holding the engine off for the whole run.
module svm_coef_loader
    import svm_coef_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [RAM_DW-1:0] ram_wdata,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    output logic              svm_hold,
    output logic              busy,
    output logic              done,
    output logic              cfg_valid,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_addr
);

    state_t            r_state;
    state_t            w_next;
    logic              r_verify;
    logic              r_ram_we;
    logic              r_b_load;
    logic              r_cfg_valid;
    logic              r_mismatch;
    logic [ADDR_W-1:0] r_word;
    logic [ADDR_W-1:0] r_mm_addr;
    logic [COEF_W-1:0] r_bias;
    logic [RAM_DW-1:0] w_asm;
    logic              w_last;
    logic              w_ready;
    logic              w_accept;
    logic              w_abort;
    logic              w_kill;
    logic              w_clr;
    logic              w_word_last;

    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_kill      = rst || w_abort;
    assign w_clr       = (start && (r_state == S_IDLE)) || w_abort;
    assign w_accept    = s_valid && w_ready;
    assign w_word_last = (r_word == ADDR_W'(N_WORDS - 1));

    svm_beat_pack u_pack (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_accept (w_accept),
        .i_data   (s_data),
        .o_asm    (w_asm),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) w_next = S_COLLECT;
                S_COLLECT: if (w_accept && w_last) w_next = r_verify ? S_RD : S_WR;
                S_WR:      w_next = w_word_last ? S_BIAS : S_COLLECT;
                S_RD:      w_next = S_CMP;
                S_CMP:     w_next = w_word_last ? S_BIAS : S_COLLECT;
                S_BIAS:    if (w_accept) w_next = S_DONE;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Abort and reset win over everything, including handshakes already in flight.
    always_comb begin
        w_ready = 1'b0;
        done    = 1'b0;
        busy    = (r_state != S_IDLE);
        if (!w_kill) begin
            w_ready = (r_state == S_COLLECT) || (r_state == S_BIAS);
            done    = (r_state == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_verify    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_b_load    <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_word      <= '0;
            r_mm_addr   <= '0;
            r_bias      <= '0;
        end else begin
            r_ram_we <= (w_next == S_WR);
            r_b_load <= 1'b0;
            if (w_abort) begin
                if (!r_verify) r_cfg_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_verify   <= verify;
                        r_mismatch <= 1'b0;
                        r_mm_addr  <= '0;
                        r_word     <= '0;
                        if (!verify) r_cfg_valid <= 1'b0;
                    end
                    S_WR: r_word <= r_word + ADDR_W'(1);
                    S_CMP: begin
                        if ((ram_rdata != w_asm) && !r_mismatch) begin
                            r_mismatch <= 1'b1;
                            r_mm_addr  <= r_word;
                        end
                        r_word <= r_word + ADDR_W'(1);
                    end
                    S_BIAS: if (w_accept) begin
                        if (!r_verify) begin
                            r_bias   <= s_data[COEF_W-1:0];
                            r_b_load <= 1'b1;
                        end else if ((s_data[COEF_W-1:0] != r_bias) && !r_mismatch) begin
                            r_mismatch <= 1'b1;
                            r_mm_addr  <= ADDR_W'(N_WORDS);
                        end
                    end
                    S_DONE: begin
                        if (!r_verify)      r_cfg_valid <= 1'b1;
                        else if (r_mismatch) r_cfg_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready       = w_ready;
    assign ram_addr      = r_word;
    assign ram_we        = r_ram_we && !w_kill;
    assign ram_wdata     = w_asm;
    assign bias          = r_bias;
    assign b_load        = r_b_load && !w_kill;
    assign svm_hold      = busy;
    assign cfg_valid     = r_cfg_valid;
    assign mismatch      = r_mismatch;
    assign mismatch_addr = r_mm_addr;

endmodule

// File: tb/tb_svm_coef_loader.sv
// Scoreboard bench for svm_coef_loader: a stream-level model predicts RAM writes,
// bias loads and run results; a negedge monitor pops and compares them.
module tb_svm_coef_loader;
    import svm_coef_loader_pkg::*;

    localparam int FULL_W = BEATS * IN_W;
    localparam int N_BEAT = N_WORDS * BEATS + 1;

    typedef logic [IN_W-1:0] beat_q_t[$];
    typedef struct { int addr; logic [RAM_DW-1:0] data; } wr_t;
    typedef struct { bit mm; int addr; bit cfg; int lat; } done_t;

    logic              clk = 1'b0;
    logic              rst, start, verify, abort, s_valid;
    logic              s_ready, ram_we, b_load, svm_hold, busy, done, cfg_valid, mismatch;
    logic [IN_W-1:0]   s_data;
    logic [ADDR_W-1:0] ram_addr, mismatch_addr;
    logic [RAM_DW-1:0] ram_wdata, ram_rdata;
    logic [COEF_W-1:0] bias;

    logic [RAM_DW-1:0] mem     [N_WORDS];
    logic [RAM_DW-1:0] ref_img [N_WORDS];
    logic [COEF_W-1:0] ref_bias;
    bit                ref_cfg;

    wr_t               wr_q[$];
    logic [COEF_W-1:0] bias_q[$];
    done_t             done_q[$];

    int n_cmp = 0, n_bad = 0, cyc = 0, cyc_first = 0;
    bit cfg_pending = 0, cfg_exp = 0;

    wr_t               mon_wr;
    done_t             mon_done;
    logic [FULL_W-1:0] mon_got, mon_exp;
    int                mon_k;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    svm_coef_loader dut (
        .clk(clk), .rst(rst), .start(start), .verify(verify), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .bias(bias), .b_load(b_load), .svm_hold(svm_hold), .busy(busy), .done(done),
        .cfg_valid(cfg_valid), .mismatch(mismatch), .mismatch_addr(mismatch_addr)
    );

    // Port A RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (int'(ram_addr) < N_WORDS) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [RAM_DW-1:0] model_word(input beat_q_t st, input int w);
        logic [FULL_W-1:0] full;
        for (int k = 0; k < BEATS; k++) full[k*IN_W +: IN_W] = st[w*BEATS + k];
        return full[RAM_DW-1:0];
    endfunction

    function automatic beat_q_t plan_stream();
        beat_q_t st;
        for (int w = 0; w < N_WORDS; w++)
            for (int k = 0; k < BEATS; k++) st.push_back({8'(w), 8'(k), 16'hA5C3});
        st.push_back(32'h0000_0F9C);
        return st;
    endfunction

    function automatic beat_q_t random_stream();
        beat_q_t st;
        for (int i = 0; i < N_BEAT; i++) st.push_back($urandom());
        return st;
    endfunction

    task automatic expect_write(input beat_q_t st, input int n_words, input bit with_bias, input int lat);
        for (int w = 0; w < n_words; w++) begin
            ref_img[w] = model_word(st, w);
            wr_q.push_back('{w, ref_img[w]});
        end
        ref_cfg = 1'b0;
        if (with_bias) begin
            ref_bias = st[N_WORDS*BEATS][COEF_W-1:0];
            ref_cfg  = 1'b1;
            bias_q.push_back(ref_bias);
            done_q.push_back('{1'b0, 0, 1'b1, lat});
        end
    endtask

    task automatic expect_verify(input beat_q_t st, input int lat);
        bit mm = 1'b0;
        int a  = 0;
        for (int w = 0; w < N_WORDS; w++)
            if (!mm && model_word(st, w) !== ref_img[w]) begin mm = 1'b1; a = w; end
        if (!mm && st[N_WORDS*BEATS][COEF_W-1:0] !== ref_bias) begin mm = 1'b1; a = N_WORDS; end
        if (mm) ref_cfg = 1'b0;
        done_q.push_back('{mm, a, ref_cfg, lat});
    endtask

    task automatic start_run(input bit v);
        start = 1'b1; verify = v;
        @(posedge clk); #1;
        start = 1'b0; verify = 1'b0;
    endtask

    task automatic drive_stream(input beat_q_t st, input int idle_pct, input int abort_at, input int busy_start_at);
        int idx = 0, guard = 0;
        bit acc;
        while (idx < st.size() && guard < 8000) begin
            s_valid = ($urandom_range(99) >= idle_pct);
            s_data  = st[idx];
            abort   = (idx == abort_at);
            if (abort) s_valid = 1'b1;
            start   = (idx == busy_start_at);
            verify  = start;
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc && idx == 0) cyc_first = cyc;
            @(posedge clk); #1;
            guard++;
            if (abort) begin abort = 1'b0; break; end
            if (acc) idx++;
        end
        s_valid = 1'b0; start = 1'b0; verify = 1'b0;
        if (abort_at < 0) check("stream_consumed", 64'(idx), 64'(st.size()));
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((wr_q.size() + bias_q.size() + done_q.size() != 0 || cfg_pending) && n < bound) begin
            @(posedge clk); #1; n++;
        end
        check("drain_pending", 64'(wr_q.size() + bias_q.size() + done_q.size()), 64'(0));
    endtask

    task automatic check_ram_image();
        int nd = 0;
        for (int w = 0; w < N_WORDS; w++) if (mem[w] !== ref_img[w]) nd++;
        check("ram_image_bad_words", 64'(nd), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        check("rst_ram_wdata_any", 64'(|ram_wdata), 64'(0));
        check("rst_bias", 64'(bias), 64'(0));
        check("rst_b_load", 64'(b_load), 64'(0));
        check("rst_svm_hold", 64'(svm_hold), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_cfg_valid", 64'(cfg_valid), 64'(0));
        check("rst_mismatch", 64'(mismatch), 64'(0));
        check("rst_mismatch_addr", 64'(mismatch_addr), 64'(0));
    endtask

    // Monitor: every DUT event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_pending) begin
                check("cfg_valid_after_done", 64'(cfg_valid), 64'(cfg_exp));
                cfg_pending = 1'b0;
            end
            if (ram_we) begin
                check("s_ready_in_wr", 64'(s_ready), 64'(0));
                if (wr_q.size() == 0) begin
                    check("ram_we_unexpected", 64'(ram_we), 64'(0));
                end else begin
                    mon_wr  = wr_q.pop_front();
                    mon_got = FULL_W'(ram_wdata);
                    mon_exp = FULL_W'(mon_wr.data);
                    mon_k   = 0;
                    for (int k = BEATS - 1; k >= 0; k--)
                        if (mon_got[k*IN_W +: IN_W] !== mon_exp[k*IN_W +: IN_W]) mon_k = k;
                    check($sformatf("ram_addr_w%0d", mon_wr.addr), 64'(ram_addr), 64'(mon_wr.addr));
                    check($sformatf("ram_wdata_w%0d_beat%0d", mon_wr.addr, mon_k),
                          64'(mon_got[mon_k*IN_W +: IN_W]), 64'(mon_exp[mon_k*IN_W +: IN_W]));
                end
            end
            if (b_load) begin
                if (bias_q.size() == 0) check("b_load_unexpected", 64'(b_load), 64'(0));
                else check("bias_value", 64'(bias), 64'(bias_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'(0));
                end else begin
                    mon_done = done_q.pop_front();
                    check("done_mismatch", 64'(mismatch), 64'(mon_done.mm));
                    check("done_mismatch_addr", 64'(mismatch_addr), 64'(mon_done.addr));
                    if (mon_done.lat >= 0)
                        check("done_latency", 64'(cyc - cyc_first), 64'(mon_done.lat));
                    cfg_exp     = mon_done.cfg;
                    cfg_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_q_t st, st_bad, rs, rs_nb;
        logic [IN_W-1:0] tmp;

        rst = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        for (int w = 0; w < N_WORDS; w++) ref_img[w] = '0;
        ref_bias = '0; ref_cfg = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs();

        // Plain write load, no stalls.
        st = plan_stream();
        expect_write(st, N_WORDS, 1'b1, N_WORDS * (BEATS + 1) + 1);
        start_run(1'b0);
        drive_stream(st, 0, -1, -1);
        wait_drain(200);
        check_ram_image();

        // Verify with identical stream.
        expect_verify(st, N_WORDS * (BEATS + 2) + 1);
        start_run(1'b1);
        drive_stream(st, 0, -1, -1);
        wait_drain(200);

        // Verify with word 7 beat 3 bit 0 flipped and a wrong bias.
        st_bad = st;
        tmp = st_bad[7*BEATS + 3]; tmp[0] = ~tmp[0]; st_bad[7*BEATS + 3] = tmp;
        st_bad[N_WORDS*BEATS] = 32'h0000_0001;
        expect_verify(st_bad, N_WORDS * (BEATS + 2) + 1);
        start_run(1'b1);
        drive_stream(st_bad, 0, -1, -1);
        wait_drain(200);

        // Backpressure with a stray start mid-run.
        expect_write(st, N_WORDS, 1'b1, -1);
        start_run(1'b0);
        drive_stream(st, 30, -1, 300);
        wait_drain(400);
        check_ram_image();

        // Abort while idle has no effect.
        abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'(0));
        check("idle_abort_cfg_valid", 64'(cfg_valid), 64'(1));

        // Abort during word 20 beat 5.
        expect_write(st, 20, 1'b0, -1);
        start_run(1'b0);
        drive_stream(st, 0, 20*BEATS + 5, -1);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_s_ready", 64'(s_ready), 64'(0));
        check("abort_cfg_valid", 64'(cfg_valid), 64'(0));
        repeat (50) @(posedge clk);
        #1 wait_drain(10);

        // Fresh random load from word 0, then verify it with stalls.
        rs = random_stream();
        expect_write(rs, N_WORDS, 1'b1, N_WORDS * (BEATS + 1) + 1);
        start_run(1'b0);
        drive_stream(rs, 0, -1, -1);
        wait_drain(200);
        check_ram_image();
        expect_verify(rs, -1);
        start_run(1'b1);
        drive_stream(rs, 20, -1, -1);
        wait_drain(400);

        // Reset while waiting for the bias beat.
        rs_nb = random_stream();
        expect_write(rs_nb, N_WORDS, 1'b0, -1);
        rs_nb.pop_back();
        start_run(1'b0);
        drive_stream(rs_nb, 0, -1, -1);
        wait_drain(100);
        repeat (3) @(posedge clk);
        #1;
        check("bias_wait_busy", 64'(busy), 64'(1));
        check("bias_wait_s_ready", 64'(s_ready), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ref_bias = '0;
        check_reset_outputs();
        repeat (5) @(posedge clk);
        #1 wait_drain(10);
        check_ram_image();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
